// File: rtl/maze_player_ctrl.sv
// maze_player_ctrl: overlays a player square on the 96x64 maze colour stream
// and moves it on button pulses. A move is armed by a press, the candidate box
// is checked against wall pixels for one whole frame, then committed at the
// following frame start only if that frame showed no wall inside the box.
// Reaching row 0 raises a sticky win flag.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   frame_begin  one-cycle pulse at the start of each OLED frame
//   pixel_index  current OLED pixel index (x = idx % 96, y = idx / 96)
//   maze_data    maze colour for the pixel_index of the previous cycle
//   btn_*        debounced single-cycle press pulses
//   oled_data    overlaid colour, one cycle after maze_data
//   player_x/y   player top-left corner
//   win          sticky goal-reached flag
module maze_player_ctrl #(
  parameter int unsigned SIZE         = 5,
  parameter int unsigned START_X      = 5,
  parameter int unsigned START_Y      = 5,
  parameter logic [15:0] WALL_COLOR   = 16'hFFFF,
  parameter logic [15:0] PLAYER_COLOR = 16'hF800,
  parameter logic [15:0] WIN_COLOR    = 16'h07E0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_begin,
  input  logic [12:0] pixel_index,
  input  logic [15:0] maze_data,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [15:0] oled_data,
  output logic [6:0]  player_x,
  output logic [5:0]  player_y,
  output logic        win
);

  localparam logic [7:0] Size8 = 8'(SIZE);

  typedef enum logic [1:0] {StIdle, StArmed, StScan} state_e;
  typedef enum logic [1:0] {DirUp, DirDown, DirLeft, DirRight} dir_e;

  state_e      state;
  dir_e        dir;
  logic [12:0] idx_d;
  logic [6:0]  cand_x;
  logic [5:0]  cand_y;
  logic        hit;

  logic               idx_valid;
  logic [7:0]         pix_x;
  logic [7:0]         pix_y;
  logic               in_player;
  logic               in_cand;
  logic signed [7:0]  next_x;
  logic signed [7:0]  next_y;
  logic               cand_ok;
  logic               any_btn;

  always_comb begin
    // idx_d is aligned with maze_data because the maze generator is registered
    idx_valid = idx_d < 13'd6144;
    pix_x     = 8'(idx_d % 13'd96);
    pix_y     = 8'(idx_d / 13'd96);

    in_player = idx_valid &&
                pix_x >= {1'b0, player_x} && pix_x < {1'b0, player_x} + Size8 &&
                pix_y >= {2'b00, player_y} && pix_y < {2'b00, player_y} + Size8;
    in_cand   = idx_valid &&
                pix_x >= {1'b0, cand_x} && pix_x < {1'b0, cand_x} + Size8 &&
                pix_y >= {2'b00, cand_y} && pix_y < {2'b00, cand_y} + Size8;

    // Signed 8-bit candidate so a step off the top/left edge shows up as negative
    next_x = signed'({1'b0, player_x});
    next_y = signed'({2'b00, player_y});
    unique case (dir)
      DirUp:    next_y = next_y - 8'sd1;
      DirDown:  next_y = next_y + 8'sd1;
      DirLeft:  next_x = next_x - 8'sd1;
      DirRight: next_x = next_x + 8'sd1;
      default:  next_x = next_x;
    endcase
    cand_ok = !next_x[7] && !next_y[7] &&
              (next_x + signed'(Size8) <= 8'sd96) &&
              (next_y + signed'(Size8) <= 8'sd64);

    any_btn = btn_up | btn_down | btn_left | btn_right;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      dir       <= DirUp;
      idx_d     <= '0;
      cand_x    <= '0;
      cand_y    <= '0;
      hit       <= 1'b0;
      oled_data <= '0;
      player_x  <= 7'(START_X);
      player_y  <= 6'(START_Y);
      win       <= 1'b0;
    end else begin
      idx_d <= pixel_index;

      if (in_player) oled_data <= win ? WIN_COLOR : PLAYER_COLOR;
      else           oled_data <= maze_data;

      unique case (state)
        StIdle: begin
          // frame_begin is not looked at here, so a same-cycle frame start is unused
          if (any_btn && !win) begin
            if (btn_up)        dir <= DirUp;
            else if (btn_down) dir <= DirDown;
            else if (btn_left) dir <= DirLeft;
            else               dir <= DirRight;
            state <= StArmed;
          end
        end
        StArmed: begin
          if (frame_begin) begin
            if (cand_ok) begin
              cand_x <= next_x[6:0];
              cand_y <= next_y[5:0];
              hit    <= 1'b0;
              state  <= StScan;
            end else begin
              state <= StIdle;
            end
          end
        end
        StScan: begin
          if (frame_begin) begin
            if (!hit) begin
              player_x <= cand_x;
              player_y <= cand_y;
              if (cand_y == '0) win <= 1'b1;
            end
            state <= StIdle;
          end else if (in_cand && maze_data == WALL_COLOR) begin
            hit <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Directed bench for maze_player_ctrl. Frames are shortened: only the pixels
// that matter are scanned, all other cycles park pixel_index off-screen.
module tb_maze_player_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_begin = 1'b0;
  logic [12:0] pixel_index = 13'd8000;
  logic [15:0] maze_data = 16'h0000;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic [15:0] oled_data;
  logic [6:0]  player_x;
  logic [5:0]  player_y;
  logic        win;

  int tests_run = 0;
  int tests_failed = 0;
  int wall_idx = -1;
  logic [12:0] sampled_idx;

  maze_player_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_begin (frame_begin),
    .pixel_index (pixel_index),
    .maze_data   (maze_data),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .oled_data   (oled_data),
    .player_x    (player_x),
    .player_y    (player_y),
    .win         (win)
  );

  always #5 clk = ~clk;

  // Registered maze generator model: colour of the index seen at the last edge
  always @(posedge clk) begin
    sampled_idx = pixel_index;
    #1;
    maze_data = (wall_idx >= 0 && int'(sampled_idx) == wall_idx) ? 16'hFFFF : 16'h0000;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // mask bits: 3=up 2=down 1=left 0=right
  task automatic press(input logic [3:0] mask);
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right} = mask;
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
  endtask

  task automatic frame();
    @(negedge clk);
    frame_begin = 1'b1;
    @(negedge clk);
    frame_begin = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Present one pixel; on return oled_data reflects that pixel
  task automatic scan_px(input int idx);
    @(negedge clk);
    pixel_index = 13'(idx);
    @(negedge clk);
    pixel_index = 13'd8000;
    @(negedge clk);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_x", 32'(player_x), 5);
    check_eq("rst_y", 32'(player_y), 5);
    check_eq("rst_win", 32'(win), 0);
    check_eq("rst_oled", 32'(oled_data), 32'h0000);

    // Overlay inside box and passthrough outside
    scan_px(485);
    check_eq("overlay_player", 32'(oled_data), 32'hF800);
    wall_idx = 0;
    scan_px(0);
    check_eq("overlay_pass", 32'(oled_data), 32'hFFFF);
    wall_idx = -1;

    // Right move commits exactly at the second frame_begin
    press(4'b0001);
    frame();
    check_eq("right_after_f1", 32'(player_x), 5);
    @(negedge clk);
    frame_begin = 1'b1;
    check_eq("right_not_early", 32'(player_x), 5);
    @(negedge clk);
    frame_begin = 1'b0;
    check_eq("right_commit", 32'(player_x), 6);

    // Wall at (10,7) blocks the right move; FSM returns to idle
    do_reset();
    press(4'b0001);
    frame();
    wall_idx = 682;
    scan_px(682);
    wall_idx = -1;
    frame();
    check_eq("wall_reject_x", 32'(player_x), 5);
    press(4'b0001);
    frame();
    frame();
    check_eq("after_reject_x", 32'(player_x), 6);

    // Up x5 reaches row 0 and wins
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      press(4'b1000);
      frame();
      frame();
      check_eq("up_y", 32'(player_y), 32'(5 - i));
      if (i == 4) check_eq("win_early", 32'(win), 0);
    end
    check_eq("win_set", 32'(win), 1);
    scan_px(5);
    check_eq("win_color", 32'(oled_data), 32'h07E0);
    press(4'b0100);
    frame();
    frame();
    check_eq("win_locked_y", 32'(player_y), 0);
    check_eq("win_sticky", 32'(win), 1);

    // Left x6: last move would go to x=-1 and is dropped
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      press(4'b0010);
      frame();
      frame();
      check_eq("left_x", 32'(player_x), (i < 5) ? 32'(5 - i) : 0);
    end
    check_eq("left_y", 32'(player_y), 5);

    // Reset asserted mid-scan, away from a clock edge
    do_reset();
    press(4'b0100);
    frame();
    frame();
    check_eq("down_y", 32'(player_y), 6);
    press(4'b0100);
    frame();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_y", 32'(player_y), 5);
    check_eq("async_rst_oled", 32'(oled_data), 0);
    @(negedge clk);
    reset = 1'b0;
    frame();
    check_eq("no_commit_y1", 32'(player_y), 5);
    frame();
    check_eq("no_commit_y2", 32'(player_y), 5);

    // Up+left together: up wins; right pressed during scan is dropped
    do_reset();
    press(4'b1010);
    frame();
    press(4'b0001);
    frame();
    check_eq("prio_y", 32'(player_y), 4);
    check_eq("prio_x", 32'(player_x), 5);
    frame();
    frame();
    check_eq("no_queue_x", 32'(player_x), 5);

    // Button and frame_begin in the same idle cycle: that frame is not used
    do_reset();
    @(negedge clk);
    btn_right = 1'b1;
    frame_begin = 1'b1;
    @(negedge clk);
    btn_right = 1'b0;
    frame_begin = 1'b0;
    frame();
    check_eq("same_cycle_x1", 32'(player_x), 5);
    frame();
    check_eq("same_cycle_x2", 32'(player_x), 6);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
